booth_seq_mult: RTL and testbench

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

---
 rtl/booth_seq_mult.sv | 139 +++++++++++++
 tb/tb_booth_seq_mult.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier with a valid/ready handshake on both sides.
// Define BOOTH_SAT_OUT_EN to add the saturated fixed-point outputs fx_out and sat.
module booth_seq_mult #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
`ifdef BOOTH_SAT_OUT_EN
  ,
  output logic [WIDTH-1:0]     fx_out,
  output logic                 sat
`endif
);

  localparam int unsigned EW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [EW-1:0]  m_q, acc_q, q_q;
  logic           qm1_q;
  logic [CW-1:0]  cnt_q;
  logic           smode_q;

  logic           accept, last_step;
  logic [EW-1:0]  a_ext, b_ext;
  logic [EW:0]    acc_x, m_x, sum;

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_q == CW'(WIDTH));
  assign a_ext     = signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
  assign b_ext     = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StCalc;
      StCalc:  if (last_step) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StCalc);
    out_valid = (state_q == StDone);
  end

  // One extra guard bit keeps the add/sub exact before the arithmetic shift.
  always_comb begin
    acc_x = {acc_q[EW-1], acc_q};
    m_x   = {m_q[EW-1], m_q};
    case ({q_q[0], qm1_q})
      2'b10:   sum = acc_x - m_x;
      2'b01:   sum = acc_x + m_x;
      default: sum = acc_x;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      smode_q <= 1'b0;
    end else if (accept) begin
      m_q     <= a_ext;
      acc_q   <= '0;
      q_q     <= b_ext;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      smode_q <= signed_mode;
    end else if (state_q == StCalc) begin
      acc_q   <= sum[EW:1];
      q_q     <= {sum[0], q_q[EW-1:1]};
      qm1_q   <= q_q[0];
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Low 2*WIDTH bits of the {Acc, Q} Booth result
  assign product = {acc_q[EW-2:0], q_q};

`ifdef BOOTH_SAT_OUT_EN
  logic [2*WIDTH-1:0] shifted;
  logic               fits_s, fits_u;

  always_comb begin
    if (smode_q) begin
      shifted = $signed(product) >>> FRAC;
    end else begin
      shifted = product >> FRAC;
    end
  end

  assign fits_s = (&shifted[2*WIDTH-1:WIDTH-1]) || !(|shifted[2*WIDTH-1:WIDTH-1]);
  assign fits_u = !(|shifted[2*WIDTH-1:WIDTH]);

  always_comb begin
    sat    = 1'b0;
    fx_out = shifted[WIDTH-1:0];
    if (smode_q) begin
      if (!fits_s) begin
        sat    = 1'b1;
        fx_out = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else if (!fits_u) begin
      sat    = 1'b1;
      fx_out = '1;
    end
  end
`endif

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=16, FRAC=8) against an arithmetic model.
// Covers the BOOTH_SAT_OUT_EN outputs when that macro is defined.
module tb_booth_seq_mult;
  localparam int W = 16;
  localparam int F = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           signed_mode = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] product;
  logic           busy;
`ifdef BOOTH_SAT_OUT_EN
  logic [W-1:0]   fx_out;
  logic           sat;
  logic [W-1:0]   fx_seen;
  logic           sat_seen;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  booth_seq_mult #(.WIDTH(W), .FRAC(F)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
`ifdef BOOTH_SAT_OUT_EN
    ,
    .fx_out      (fx_out),
    .sat         (sat)
`endif
  );

  always #5 clk = ~clk;

  function automatic longint full_prod(logic [W-1:0] x, logic [W-1:0] y, bit sm);
    longint ex, ey;
    ex = sm ? longint'($signed(x)) : longint'(x);
    ey = sm ? longint'($signed(y)) : longint'(y);
    return ex * ey;
  endfunction

  function automatic logic [2*W-1:0] model_prod(logic [W-1:0] x, logic [W-1:0] y, bit sm);
    longint p;
    p = full_prod(x, y, sm);
    return p[2*W-1:0];
  endfunction

  task automatic model_fx(input logic [W-1:0] x, input logic [W-1:0] y, input bit sm,
                          output logic [W-1:0] fx, output logic s);
    longint p, sh, lo, hi;
    p  = full_prod(x, y, sm);
    sh = p >>> F;
    lo = sm ? -(longint'(1) <<< (W - 1)) : 0;
    hi = sm ? (longint'(1) <<< (W - 1)) - 1 : (longint'(1) <<< W) - 1;
    s  = 1'b0;
    if (sh > hi) begin sh = hi; s = 1'b1; end
    if (sh < lo) begin sh = lo; s = 1'b1; end
    fx = sh[W-1:0];
  endtask

  // Runs one full operation; inputs are scrambled while the DUT is busy.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit sm,
                       output logic [2*W-1:0] res, output int lat, output bit ok);
    int n;
    ok = 1'b1; lat = 0; res = '0;
    a = x; b = y; signed_mode = sm; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) begin ok = 1'b0; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    if (out_valid !== 1'b1) begin ok = 1'b0; return; end
    res = product;
`ifdef BOOTH_SAT_OUT_EN
    fx_seen = fx_out; sat_seen = sat;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (product !== '0) begin n_fail++; $display("FAIL reset_product: got %h expected 0", product); end
`ifdef BOOTH_SAT_OUT_EN
    n_tests++; if (fx_out !== '0 || sat !== 1'b0) begin
      n_fail++; $display("FAIL reset_fx: got %h/%b expected 0/0", fx_out, sat);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [W-1:0]   va[6]  = '{16'hFFFD, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
    logic [W-1:0]   vb[6]  = '{16'h0005, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF};
    bit             vs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2*W-1:0] ve[6]  = '{32'hFFFFFFF1, 32'hFFFE0001, 32'h40000000, 32'hC0008000,
                               32'h40000000, 32'h00000001};
    logic [2*W-1:0] r;
    int lat;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vs[i], r, lat, ok);
      n_tests++; if (!ok || r !== ve[i]) begin
        n_fail++; $display("FAIL directed_%0d: got %h expected %h (ok=%0d)", i, r, ve[i], ok);
      end
      n_tests++; if (lat != W + 1) begin
        n_fail++; $display("FAIL directed_latency_%0d: got %0d expected %0d", i, lat, W + 1);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [2*W-1:0] exp_p;
    int n;
    a = 16'h1234; b = 16'hABCD; signed_mode = 1'b1; in_valid = 1'b1;
    exp_p = model_prod(16'h1234, 16'hABCD, 1'b1);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b expected 1", busy); end
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (product !== exp_p || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_%0d: got %h/%b expected %h/1", i, product, out_valid, exp_p);
      end
      n_tests++; if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready_%0d: got %b expected 0", i, in_ready);
      end
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_calc;
    logic [2*W-1:0] r;
    int lat, n;
    bit ok;
    a = 16'h1111; b = 16'h2222; signed_mode = 1'b0; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midcalc_busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midcalc_reset: got ov=%b ir=%b busy=%b expected 0/1/0", out_valid, in_ready, busy);
    end
    n_tests++; if (product !== '0) begin n_fail++; $display("FAIL midcalc_product: got %h expected 0", product); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'd7, 16'd9, 1'b0, r, lat, ok);
    n_tests++; if (!ok || r !== 32'h0000003F) begin
      n_fail++; $display("FAIL after_reset_op: got %h expected 0000003f (ok=%0d)", r, ok);
    end
    n_tests++; if (lat != W + 1) begin n_fail++; $display("FAIL after_reset_latency: got %0d expected %0d", lat, W + 1); end
  endtask

  task automatic test_random;
    logic [W-1:0] corners[5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [W-1:0] x, y;
    logic [2*W-1:0] r;
    bit sm, ok;
    int lat;
    for (int i = 0; i < 24; i++) begin
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      sm = 1'($urandom);
      do_op(x, y, sm, r, lat, ok);
      n_tests++; if (!ok || r !== model_prod(x, y, sm)) begin
        n_fail++; $display("FAIL random_%0d: a=%h b=%h s=%0d got %h expected %h", i, x, y, sm, r,
                           model_prod(x, y, sm));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] expq[$];
    int acc_n, res_n, cyc, t_prev;
    bit acc, fire;
    acc_n = 0; res_n = 0; cyc = 0; t_prev = -1;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    while (res_n < 8 && cyc < 400) begin
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        n_tests++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected: got %h expected none", product);
        end else begin
          if (product !== expq[0]) begin
            n_fail++; $display("FAIL b2b_result_%0d: got %h expected %h", res_n, product, expq[0]);
          end
          void'(expq.pop_front());
        end
        if (t_prev >= 0) begin
          n_tests++; if (cyc - t_prev != W + 3) begin
            n_fail++; $display("FAIL b2b_interval_%0d: got %0d expected %0d", res_n, cyc - t_prev, W + 3);
          end
        end
        t_prev = cyc;
        res_n++;
      end
      if (acc) expq.push_back(model_prod(a, b, signed_mode));
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_n++;
        if (acc_n == 8) in_valid = 1'b0;
        else begin a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom); end
      end
    end
    n_tests++; if (res_n != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", res_n); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

`ifdef BOOTH_SAT_OUT_EN
  task automatic test_sat;
    logic [W-1:0] va[3] = '{16'h0300, 16'h7FFF, 16'h7FFF};
    logic [W-1:0] vb[3] = '{16'h0200, 16'h7FFF, 16'h8000};
    logic [W-1:0] vf[3] = '{16'h0600, 16'h7FFF, 16'h8000};
    bit           vs[3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] x, y, efx;
    logic [2*W-1:0] r;
    logic es;
    bit sm, ok;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b1, r, lat, ok);
      n_tests++; if (!ok || fx_seen !== vf[i] || sat_seen !== vs[i]) begin
        n_fail++; $display("FAIL sat_directed_%0d: got %h/%b expected %h/%b", i, fx_seen, sat_seen, vf[i], vs[i]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      x = W'($urandom); y = W'($urandom); sm = 1'($urandom);
      if (i % 3 == 0) y = W'($urandom_range(0, 511));
      do_op(x, y, sm, r, lat, ok);
      model_fx(x, y, sm, efx, es);
      n_tests++; if (!ok || fx_seen !== efx || sat_seen !== es) begin
        n_fail++; $display("FAIL sat_random_%0d: a=%h b=%h s=%0d got %h/%b expected %h/%b", i, x, y, sm,
                           fx_seen, sat_seen, efx, es);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    test_back_to_back();
`ifdef BOOTH_SAT_OUT_EN
    test_sat();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
